// File: rtl/mc_controller.sv
// Multicycle MIPS-style main controller: Moore FSM plus ALU decoder.
// Optional addi support is enabled by defining MC_ADDI_EN.
module mc_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output logic       pcwrite,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic       branch,
  output logic       alusrca,
  output logic       iord,
  output logic       memtoreg,
  output logic       regdst,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic [3:0] state,
  output logic       illegal
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_RTYP = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  state_t     r_state;
  state_t     w_next;
  state_t     w_dec;
  logic       w_bad_op;
  logic [1:0] w_aluop;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next   = S_FETCH;
    w_bad_op = 1'b0;
    case (r_state)
      S_FETCH:   w_next = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW,
          OP_SW:   w_next = S_MEMADR;
          OP_RTYP: w_next = S_EXECUTE;
          OP_BEQ:  w_next = S_BRANCH;
`ifdef MC_ADDI_EN
          OP_ADDI: w_next = S_ADDIEX;
`endif
          OP_J:    w_next = S_JUMP;
          default: begin
            w_next   = S_FETCH;
            w_bad_op = 1'b1;
          end
        endcase
      end
      S_MEMADR:
        w_next = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   w_next = S_MEMWB;
      S_EXECUTE: w_next = S_ALUWB;
`ifdef MC_ADDI_EN
      S_ADDIEX:  w_next = S_ADDIWB;
`endif
      default:   w_next = S_FETCH;
    endcase
  end

  // Mux selects under reset show the FETCH decode; strobes are masked below.
  assign w_dec = reset ? S_FETCH : r_state;

  always_comb begin
    pcwrite  = 1'b0;
    memwrite = 1'b0;
    irwrite  = 1'b0;
    regwrite = 1'b0;
    branch   = 1'b0;
    alusrca  = 1'b0;
    iord     = 1'b0;
    memtoreg = 1'b0;
    regdst   = 1'b0;
    alusrcb  = 2'b00;
    pcsrc    = 2'b00;
    w_aluop  = 2'b00;
    case (w_dec)
      S_FETCH: begin
        irwrite = 1'b1;
        pcwrite = 1'b1;
        alusrcb = 2'b01;
      end
      S_DECODE:  alusrcb = 2'b11;
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_MEMRD: begin
        iord     = 1'b1;
        memtoreg = 1'b1;
      end
      S_MEMWB: begin
        iord     = 1'b1;
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      S_MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      S_EXECUTE: begin
        alusrca = 1'b1;
        w_aluop = 2'b10;
      end
      S_ALUWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      S_BRANCH: begin
        alusrca = 1'b1;
        w_aluop = 2'b01;
        pcsrc   = 2'b01;
        branch  = 1'b1;
      end
`ifdef MC_ADDI_EN
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_ADDIWB:  regwrite = 1'b1;
`endif
      S_JUMP: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      default: ;
    endcase
    if (reset) begin
      pcwrite  = 1'b0;
      memwrite = 1'b0;
      irwrite  = 1'b0;
      regwrite = 1'b0;
      branch   = 1'b0;
    end
  end

  always_comb begin
    alucontrol = 3'b010;
    case (w_aluop)
      2'b01: alucontrol = 3'b110;
      2'b10: begin
        case (funct)
          6'b100000: alucontrol = 3'b010;
          6'b100010: alucontrol = 3'b110;
          6'b100100: alucontrol = 3'b000;
          6'b100101: alucontrol = 3'b001;
          6'b101010: alucontrol = 3'b111;
          default:   alucontrol = 3'b010;
        endcase
      end
      default: alucontrol = 3'b010;
    endcase
  end

  assign illegal = w_bad_op & ~reset;
  assign state   = r_state;

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: instruction-level model
// predicts the state trace and all outputs every cycle.
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] op = 6'd0;
  logic [5:0] funct = 6'd0;
  logic       pcwrite, memwrite, irwrite, regwrite, branch;
  logic       alusrca, iord, memtoreg, regdst;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic [3:0] state;
  logic       illegal;

  always #5 clk = ~clk;

  mc_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct),
    .pcwrite(pcwrite), .memwrite(memwrite), .irwrite(irwrite),
    .regwrite(regwrite), .branch(branch), .alusrca(alusrca),
    .iord(iord), .memtoreg(memtoreg), .regdst(regdst),
    .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol),
    .state(state), .illegal(illegal)
  );

  wire [16:0] w_dut = {pcwrite, memwrite, irwrite, regwrite, branch,
                       alusrca, iord, memtoreg, regdst, alusrcb,
                       pcsrc, alucontrol, illegal};

  typedef struct packed {
    logic [3:0] st;
    logic       rst;
  } ent_t;

  ent_t exp_q[$];
  ent_t ce;
  int   total = 0;
  int   bad = 0;

  function automatic logic legal_op(input logic [5:0] o);
    case (o)
      6'b100011, 6'b101011, 6'b000000,
      6'b000100, 6'b000010: return 1'b1;
`ifdef MC_ADDI_EN
      6'b001000: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] rfunc(input logic [5:0] f);
    case (f)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  // Expected outputs for a state, straight from the per-state table.
  function automatic logic [16:0] exp_out(input logic [3:0] st,
      input logic rst, input logic [5:0] o, input logic [5:0] f);
    logic pw, mw, iw, rw, br, asa, iod, mtr, rd, il;
    logic [1:0] asb, ps, aop;
    logic [2:0] ac;
    {pw, mw, iw, rw, br, asa, iod, mtr, rd, il} = '0;
    asb = 2'b00; ps = 2'b00; aop = 2'b00;
    if (rst) st = 4'd0;
    case (st)
      4'd0:  begin iw = 1; pw = 1; asb = 2'b01; end
      4'd1:  begin asb = 2'b11; il = !legal_op(o); end
      4'd2:  begin asa = 1; asb = 2'b10; end
      4'd3:  begin iod = 1; mtr = 1; end
      4'd4:  begin iod = 1; mtr = 1; rw = 1; end
      4'd5:  begin iod = 1; mw = 1; end
      4'd6:  begin asa = 1; aop = 2'b10; end
      4'd7:  begin rd = 1; rw = 1; end
      4'd8:  begin asa = 1; aop = 2'b01; ps = 2'b01; br = 1; end
`ifdef MC_ADDI_EN
      4'd9:  begin asa = 1; asb = 2'b10; end
      4'd10: rw = 1;
`endif
      4'd11: begin ps = 2'b10; pw = 1; end
      default: ;
    endcase
    ac = (aop == 2'b01) ? 3'b110 :
         (aop == 2'b10) ? rfunc(f) : 3'b010;
    if (rst) {pw, mw, iw, rw, br, il} = '0;
    return {pw, mw, iw, rw, br, asa, iod, mtr, rd, asb, ps, ac, il};
  endfunction

  task automatic push(input logic [3:0] st, input logic rst);
    ent_t e;
    e.st = st;
    e.rst = rst;
    exp_q.push_back(e);
  endtask

  // Instruction path as a list of visited states, FETCH first.
  task automatic push_path(input logic [5:0] o, output int n);
    int p[$];
    case (o)
      6'b100011: p = '{0, 1, 2, 3, 4};
      6'b101011: p = '{0, 1, 2, 5};
      6'b000000: p = '{0, 1, 6, 7};
      6'b000100: p = '{0, 1, 8};
      6'b000010: p = '{0, 1, 11};
`ifdef MC_ADDI_EN
      6'b001000: p = '{0, 1, 9, 10};
`endif
      default:   p = '{0, 1};
    endcase
    n = p.size();
    foreach (p[i]) push(p[i][3:0], 1'b0);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      ce = exp_q.pop_front();
      total++;
      if (state !== ce.st) begin
        bad++;
        $display("FAIL state: got %0d want %0d", state, ce.st);
      end
      total++;
      if (w_dut !== exp_out(ce.st, ce.rst, op, funct)) begin
        bad++;
        $display("FAIL outputs st=%0d op=%b: got %h want %h",
                 ce.st, op, w_dut, exp_out(ce.st, ce.rst, op, funct));
      end
    end
  end

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL timeout: got %0d left want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic run(input logic [5:0] o, input logic [5:0] f,
                     input int ncyc);
    int n;
    op = o;
    funct = f;
    push_path(o, n);
    total++;
    if (n != ncyc) begin
      bad++;
      $display("FAIL cycles op=%b: got %0d want %0d", o, n, ncyc);
    end
    drain();
    @(posedge clk);
    #1;
  endtask

  task automatic pin(input string nm, input logic [16:0] got,
                     input logic [16:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  initial begin
    pin("pin_branch", exp_out(4'd8, 1'b0, 6'b000100, 6'd0),
        17'b0_0_0_0_1_1_0_0_0_00_01_110_0);
    pin("pin_slt", exp_out(4'd6, 1'b0, 6'd0, 6'b101010),
        17'b0_0_0_0_0_1_0_0_0_00_00_111_0);
    pin("pin_rst", exp_out(4'd5, 1'b1, 6'b101011, 6'd0),
        17'b0_0_0_0_0_0_0_0_0_01_00_010_0);
    pin("pin_bad", exp_out(4'd1, 1'b0, 6'b111111, 6'd0),
        17'b0_0_0_0_0_0_0_0_0_11_00_010_1);

    @(posedge clk);
    #1;
    repeat (3) push(4'd0, 1'b1);
    drain();
    @(posedge clk);
    #1;
    reset = 1'b0;

    run(6'b100011, 6'd0, 5);
    run(6'b101011, 6'd0, 4);
    run(6'b000000, 6'b101010, 4);
    run(6'b000000, 6'b100000, 4);
    run(6'b000000, 6'b100010, 4);
    run(6'b000000, 6'b100100, 4);
    run(6'b000000, 6'b100101, 4);
    run(6'b000000, 6'b011111, 4);
    run(6'b000100, 6'd0, 3);
    run(6'b000010, 6'd0, 3);
    run(6'b111111, 6'd0, 2);
`ifdef MC_ADDI_EN
    run(6'b001000, 6'd0, 4);
`else
    run(6'b001000, 6'd0, 2);
`endif

    op = 6'b101011;
    funct = 6'd0;
    push(4'd0, 1'b0);
    push(4'd1, 1'b0);
    push(4'd2, 1'b0);
    drain();
    @(posedge clk);
    #1;
    reset = 1'b1;
    push(4'd5, 1'b1);
    drain();
    @(posedge clk);
    #1;
    reset = 1'b0;

    run(6'b100011, 6'd0, 5);
    run(6'b000100, 6'd0, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 SHALL have no parameters; all widths are fixed.
REQ-002 SHALL have clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have op  input  6  opcode field of the instruction register.
REQ-005 SHALL have funct  input  6  funct field of the instruction register.
REQ-006 SHALL have pcwrite, memwrite, irwrite, regwrite, branch  output  1 each  write/branch strobes to the datapath.
REQ-007 SHALL have alusrca, iord, memtoreg, regdst  output  1 each  datapath mux selects; memtoreg also enables the memory-data register.
REQ-008 SHALL have alusrcb, pcsrc  output  2 each  datapath mux selects.
REQ-009 SHALL have alucontrol  output  3  ALU operation: 010 add, 110 sub, 000 and, 001 or, 111 slt.
REQ-010 SHALL have state  output  4  current FSM state, for debug.
REQ-011 SHALL have illegal  output  1  one-cycle pulse when DECODE sees an unsupported opcode.

Function
REQ-012 SHALL implement a Moore FSM with these state encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11.
REQ-013 SHALL transition FETCH->DECODE unconditionally.
REQ-014 SHALL transition DECODE by op:
- 100011 (lw) or 101011 (sw) -> MEMADR
- 000000 -> EXECUTE
- 000100 -> BRANCH
- 001000 -> ADDIEX
- 000010 -> JUMP
- any other op -> FETCH, with illegal=1 for that DECODE cycle.
REQ-015 SHALL transition MEMADR->MEMRD when op=lw and MEMADR->MEMWR otherwise, then MEMRD->MEMWB and EXECUTE->ALUWB, and ADDIEX->ADDIWB; MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB and JUMP SHALL return to FETCH.
REQ-016 SHALL drive outputs per state (unlisted outputs 0; aluop is internal):
- FETCH: irwrite=1, pcwrite=1, alusrcb=01, aluop=00
- DECODE: alusrcb=11, aluop=00
- MEMADR: alusrca=1, alusrcb=10, aluop=00
- MEMRD: iord=1, memtoreg=1
- MEMWB: iord=1, memtoreg=1, regwrite=1
- MEMWR: iord=1, memwrite=1
- EXECUTE: alusrca=1, alusrcb=00, aluop=10
- ALUWB: regdst=1, regwrite=1
- BRANCH: alusrca=1, aluop=01, pcsrc=01, branch=1
- ADDIEX: alusrca=1, alusrcb=10, aluop=00
- ADDIWB: regwrite=1
- JUMP: pcsrc=10, pcwrite=1.
REQ-017 SHALL decode alucontrol combinationally from aluop:
- aluop=00 -> 010; aluop=01 -> 110
- aluop=10 by funct: 100000->010, 100010->110, 100100->000, 100101->001, 101010->111, any other funct -> 010.
REQ-018 SHALL take exactly these cycles per instruction, FETCH inclusive: lw 5; sw, R-type and addi 4; beq and j 3; illegal 2.
REQ-019 SHALL force an unused state encoding (12-15) to FETCH on the next edge with all strobes 0 while in it.
REQ-020 SHALL NOT evaluate branch&zero internally; the branch decision belongs to the datapath.

Reset
REQ-021 SHALL set state=FETCH on any clk edge with reset=1, including mid-instruction.
REQ-022 SHALL hold pcwrite, memwrite, irwrite, regwrite, branch and illegal at 0 while reset=1; mux selects follow the FETCH decode.
REQ-023 SHALL perform the first FETCH (irwrite=1, pcwrite=1) in the first cycle after reset deasserts.

Configuration
REQ-024 SHALL use macro MC_ADDI_EN: when defined, op=001000 follows DECODE->ADDIEX->ADDIWB->FETCH.
REQ-025 SHALL, without MC_ADDI_EN, treat op=001000 as illegal (DECODE->FETCH, illegal pulse); ADDIEX and ADDIWB become unused encodings handled per REQ-019.

Verification
REQ-026 SHALL cover: reset held 3 cycles, then released -> state=0 and strobes 0 during reset; cycle 1 after release irwrite=pcwrite=1.
REQ-027 SHALL cover: op=100011 -> states 0,1,2,3,4,0; regwrite=1 only in state 4; iord=1 in states 3-4.
REQ-028 SHALL cover: op=000000 with funct=101010 -> state 6 shows alucontrol=111; state 7 shows regdst=1, regwrite=1; then 0.
REQ-029 SHALL cover: op=000100 -> states 0,1,8,0 with branch=1, pcsrc=01, alucontrol=110 in state 8; op=000010 -> 0,1,11,0 with pcwrite=1, pcsrc=10.
REQ-030 SHALL cover: op=111111 -> illegal=1 in state 1 only, then state 0; op=001000 -> 4-cycle addi with MC_ADDI_EN, illegal pulse without.
REQ-031 SHALL cover: reset asserted in MEMWR (state 5) -> memwrite=0 that cycle and state=0 next edge.
